encrypt_pipe_shift_xor_tx: RTL and testbench
============================================

# encrypt_pipe_shift_xor_tx

Encryption-side XOR stage: the transmitting end of the XOR/scramble link terminated by the decryption XOR stage. Accepts plaintext bytes over a valid/ready handshake, buffers them in a small FIFO, inverse-permutes each byte with the `PERM_0..PERM_7` bit map, and XORs it with a rotating key (k1 → k2 → k3). It emits one byte per cycle on `encrypted_valid`, with the same key schedule the decryptor applies. Its output drives the decryptor's `en`/`din` directly, and there is no backpressure from downstream.

## Interface
- `DEPTH`, default 4: input FIFO depth; must be a power of two, ≥ 2.
- `clk`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `mode`  in  1  1 = encrypt enabled (FIFO pops allowed); 0 = hold, no pops.
- `din`  in  8  plaintext byte.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  FIFO can accept; a byte transfers when `din_valid && din_ready`.
- `k1`, `k2`, `k3`  in  8 each  keys; sampled live when used.
- `rot_freq`  in  3  key rotates after `rot_freq+1` consecutive emitted bytes.
- `encrypted_data`  out  8  ciphertext byte.
- `encrypted_valid`  out  1  `encrypted_data` is valid this cycle.
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Inverse permutation.** `perm[i] = fifo_head[PERM_i]` for i = 0..7, so that the decryptor's `P(x)` satisfies `P(perm) = fifo_head`. Then `encrypted_data = perm ^ key`.
- **FIFO.**
  - Push on `din_valid && din_ready`.
  - `din_ready = (fifo_level < DEPTH) && !rst`.
  - Pop when `mode == 1` and `fifo_level != 0`.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo DEPTH.
- **Emission.** Each pop registers one output byte with `encrypted_valid = 1` the following cycle. A cycle with no pop registers `encrypted_valid = 0` and `encrypted_data = 0x00`.
- **Key schedule.** It is indexed by n, the position of the byte within a burst of pops on consecutive cycles.
  - n = 0 uses k1.
  - n ≥ 1 uses K(floor((n−1)/(rot_freq+1)) mod 3), where K(0) = k1, K(1) = k2, K(2) = k3.
  - Implementation: one-hot selector (reset 001, rotate 001 → 010 → 100 → 001), a 3-bit counter, and a registered `curr_key`.
  - On each pop:
    - `curr_key <= K(sel)`.
    - If `cnt == rot_freq`: `sel` rotates and `cnt <= 0`.
    - Otherwise: `cnt <= cnt + 1`.
  - Any cycle without a pop (FIFO empty or `mode == 0`) restarts the schedule: `curr_key <= k1`, `sel <= 001`, `cnt <= 0`. This matches the decryptor, which restarts its schedule whenever its `en` is low.
- **Reset values.**
  - `encrypted_data = 0x00`, `encrypted_valid = 0`, `fifo_level = 0`, `din_ready = 0` while `rst` is high.
  - FIFO emptied; `sel = 001`, `cnt = 0`, `curr_key = k1`.
- **Reset mid-burst.** In-flight and buffered bytes are discarded; no partial output is produced.

## Timing
- **Latency.** A byte accepted in cycle t into an empty FIFO with `mode = 1` is popped at t+1 and appears on `encrypted_data`/`encrypted_valid` at t+2.
- **Throughput.** One byte per cycle sustained when `din_valid` and `mode` are held high.
- **Mode change.** `mode` falling stops pops in the same cycle, so `encrypted_valid` is low from the next cycle. `mode` rising pops in the same cycle.
- **Full FIFO.** `din_ready` is low while `fifo_level == DEPTH`, even if a pop occurs that cycle. There is no simultaneous push-on-full.
- **Key and `rot_freq` changes.** Changes mid-burst take effect at the next key load; there is no retroactive effect.

## Test plan
Bytes 0x00 and 0xFF are invariant under any permutation, so the expected values below hold for every `PERM` map.
- **Reset.** Hold `rst` for 3 cycles with `din_valid` high → `din_ready` = 0, `encrypted_valid` = 0, `encrypted_data` = 0x00, `fifo_level` = 0. After release, `din_ready` = 1 on the next cycle.
- **Rotation every byte.** `rot_freq = 0`, keys 0x11/0x22/0x33, 7 back-to-back bytes of 0x00 → outputs 11, 11, 22, 33, 11, 22, 33 on consecutive cycles, the first 2 cycles after the first accept.
- **Rotation every two bytes.** `rot_freq = 1`, keys 0xA0/0xB0/0xC0, 6 bytes of 0xFF → 5F, 5F, 5F, 4F, 4F, 3F.
- **Gap restarts schedule.** `rot_freq = 0`, 3 bytes of 0x00, one idle cycle, then 2 bytes → 11, 11, 22, valid-low cycle, 11, 11.
- **Backpressure.** `mode = 0`, offer 6 bytes → 4 accepted, `din_ready` low, `fifo_level` = 4, no valid output. Set `mode = 1` → 4 consecutive valid outputs; the remaining 2 bytes are accepted as space frees.
- **Round trip.** Chain with the decryption XOR stage using random bytes, random `rot_freq`, and random gaps, plus one mid-burst `rst` → decryptor output equals the plaintext for every byte not discarded by the reset.

Source files
------------

// File: rtl/encrypt_pipe_shift_xor_tx.sv
// Transmit-side XOR scrambler: FIFO-buffered plaintext, inverse bit permutation,
// then XOR with a k1/k2/k3 rotating key restarted on every gap in the pop stream.
module encrypt_pipe_shift_xor_tx #(
  parameter int DEPTH  = 4,
  parameter int PERM_0 = 3,
  parameter int PERM_1 = 7,
  parameter int PERM_2 = 0,
  parameter int PERM_3 = 5,
  parameter int PERM_4 = 1,
  parameter int PERM_5 = 6,
  parameter int PERM_6 = 2,
  parameter int PERM_7 = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic [7:0]                 din,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic [7:0]                 k1,
  input  logic [7:0]                 k2,
  input  logic [7:0]                 k3,
  input  logic [2:0]                 rot_freq,
  output logic [7:0]                 encrypted_data,
  output logic                       encrypted_valid,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic [7:0]    perm;

  logic [2:0]    sel;
  logic [2:0]    cnt;
  logic [7:0]    curr_key;
  logic [7:0]    key_sel;

  assign din_ready  = (level < LW'(DEPTH)) && !rst;
  assign push       = din_valid && din_ready;
  assign pop        = mode && (level != '0);
  assign fifo_level = level;
  assign head       = mem[rd_ptr];

  // Inverse of the decryptor's permutation P, so that P(perm) == head.
  assign perm = {head[PERM_7], head[PERM_6], head[PERM_5], head[PERM_4],
                 head[PERM_3], head[PERM_2], head[PERM_1], head[PERM_0]};

  always_comb begin
    key_sel = k1;
    if (sel[1]) key_sel = k2;
    else if (sel[2]) key_sel = k3;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Key schedule mirrors the decryptor: any cycle without a pop restarts it at k1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel      <= 3'b001;
      cnt      <= '0;
      curr_key <= k1;
    end else if (pop) begin
      curr_key <= key_sel;
      if (cnt == rot_freq) begin
        sel <= {sel[1:0], sel[2]};
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      sel      <= 3'b001;
      cnt      <= '0;
      curr_key <= k1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      encrypted_valid <= 1'b0;
      encrypted_data  <= 8'h00;
    end else begin
      encrypted_valid <= pop;
      encrypted_data  <= pop ? (perm ^ curr_key) : 8'h00;
    end
  end

endmodule

// File: tb/tb_encrypt_pipe_shift_xor_tx.sv
// Self-checking bench for encrypt_pipe_shift_xor_tx: directed key-schedule cases,
// backpressure, randomized traffic against a queue model, and a decrypting round trip.
module tb_encrypt_pipe_shift_xor_tx;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [7:0]    din;
  logic          din_valid;
  logic          din_ready;
  logic [7:0]    k1, k2, k3;
  logic [2:0]    rot_freq;
  logic [7:0]    encrypted_data;
  logic          encrypted_valid;
  logic [LW-1:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_valid;
  logic [7:0] m_data;
  logic [7:0] m_pt;
  logic       m_prev_pop;
  int         m_n;

  encrypt_pipe_shift_xor_tx #(
    .DEPTH(DEPTH),
    .PERM_0(3), .PERM_1(7), .PERM_2(0), .PERM_3(5),
    .PERM_4(1), .PERM_5(6), .PERM_6(2), .PERM_7(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .din(din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .k1(k1),
    .k2(k2),
    .k3(k3),
    .rot_freq(rot_freq),
    .encrypted_data(encrypted_data),
    .encrypted_valid(encrypted_valid),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  function automatic int perm_idx(input int i);
    case (i)
      0: return 3;
      1: return 7;
      2: return 0;
      3: return 5;
      4: return 1;
      5: return 6;
      6: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [7:0] permute(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[perm_idx(i)];
    return r;
  endfunction

  function automatic logic [7:0] unpermute(input logic [7:0] y);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[perm_idx(i)] = y[i];
    return r;
  endfunction

  function automatic logic [7:0] key_for(input int n, input int rf);
    int s;
    if (n == 0) return k1;
    s = ((n - 1) / (rf + 1)) % 3;
    case (s)
      0: return k1;
      1: return k2;
      default: return k3;
    endcase
  endfunction

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    logic ready;
    logic pop;
    if (rst) begin
      q.delete();
      m_valid    = 1'b0;
      m_data     = 8'h00;
      m_prev_pop = 1'b0;
      m_n        = 0;
    end else begin
      ready = (q.size() < DEPTH);
      pop   = mode && (q.size() != 0);
      if (pop) begin
        m_n    = m_prev_pop ? m_n + 1 : 0;
        m_pt   = q.pop_front();
        m_data = permute(m_pt) ^ key_for(m_n, int'(rot_freq));
      end else begin
        m_data = 8'h00;
      end
      m_valid    = pop;
      m_prev_pop = pop;
      if (din_valid && ready) q.push_back(din);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; din_valid = 1'b1; din = 8'hAA;
    rot_freq = 3'd0; k1 = 8'h11; k2 = 8'h22; k3 = 8'h33;
    repeat (3) begin
      tick();
      n_checks += 4;
      if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_din_ready got %b want 0", din_ready); end
      if (encrypted_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", encrypted_valid); end
      if (encrypted_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", encrypted_data); end
      if (fifo_level !== '0) begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    end
    rst = 1'b0; din_valid = 1'b0;
    tick();
    n_checks += 2;
    if (din_ready !== 1'b1) begin n_fail++; $display("FAIL release_din_ready got %b want 1", din_ready); end
    if (fifo_level !== '0) begin n_fail++; $display("FAIL release_level got %0d want 0", fifo_level); end
  endtask

  task automatic test_rot_every_byte();
    logic [7:0] exp [7];
    exp = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33};
    rot_freq = 3'd0; k1 = 8'h11; k2 = 8'h22; k3 = 8'h33; mode = 1'b1; din = 8'h00;
    idle(2);
    for (int c = 0; c < 10; c++) begin
      din_valid = (c < 7);
      tick();
      n_checks += 2;
      if (c >= 1 && c <= 7) begin
        if (encrypted_valid !== 1'b1) begin n_fail++; $display("FAIL rot0_valid cyc %0d got %b want 1", c, encrypted_valid); end
        if (encrypted_data !== exp[c-1]) begin n_fail++; $display("FAIL rot0_data cyc %0d got %h want %h", c, encrypted_data, exp[c-1]); end
      end else begin
        if (encrypted_valid !== 1'b0) begin n_fail++; $display("FAIL rot0_idle_valid cyc %0d got %b want 0", c, encrypted_valid); end
        if (encrypted_data !== 8'h00) begin n_fail++; $display("FAIL rot0_idle_data cyc %0d got %h want 00", c, encrypted_data); end
      end
    end
  endtask

  task automatic test_rot_every_two();
    logic [7:0] exp [6];
    exp = '{8'h5F, 8'h5F, 8'h5F, 8'h4F, 8'h4F, 8'h3F};
    rot_freq = 3'd1; k1 = 8'hA0; k2 = 8'hB0; k3 = 8'hC0; mode = 1'b1; din = 8'hFF;
    idle(2);
    for (int c = 0; c < 9; c++) begin
      din_valid = (c < 6);
      tick();
      n_checks += 1;
      if (c >= 1 && c <= 6) begin
        if (encrypted_valid !== 1'b1 || encrypted_data !== exp[c-1]) begin
          n_fail++; $display("FAIL rot1_out cyc %0d got v=%b %h want v=1 %h", c, encrypted_valid, encrypted_data, exp[c-1]);
        end
      end else if (encrypted_valid !== 1'b0) begin
        n_fail++; $display("FAIL rot1_idle cyc %0d got v=%b want 0", c, encrypted_valid);
      end
    end
  endtask

  task automatic test_gap_restart();
    logic       vin [9];
    logic       exp_v [9];
    logic [7:0] exp_d [9];
    vin   = '{1, 1, 1, 0, 1, 1, 0, 0, 0};
    exp_v = '{0, 1, 1, 1, 0, 1, 1, 0, 0};
    exp_d = '{8'h00, 8'h11, 8'h11, 8'h22, 8'h00, 8'h11, 8'h11, 8'h00, 8'h00};
    rot_freq = 3'd0; k1 = 8'h11; k2 = 8'h22; k3 = 8'h33; mode = 1'b1; din = 8'h00;
    idle(2);
    for (int c = 0; c < 9; c++) begin
      din_valid = vin[c];
      tick();
      n_checks += 1;
      if (encrypted_valid !== exp_v[c] || encrypted_data !== exp_d[c]) begin
        n_fail++; $display("FAIL gap_out cyc %0d got v=%b %h want v=%b %h", c, encrypted_valid, encrypted_data, exp_v[c], exp_d[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b [6];
    int idx;
    int nout;
    logic acc;
    logic [7:0] want;
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    rot_freq = 3'd0; k1 = 8'h11; k2 = 8'h22; k3 = 8'h33;
    mode = 1'b0;
    idle(2);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      din_valid = 1'b1; din = b[idx];
      acc = (q.size() < DEPTH);
      tick();
      if (acc) idx++;
      n_checks += 1;
      if (encrypted_valid !== 1'b0) begin n_fail++; $display("FAIL bp_hold_valid cyc %0d got %b want 0", c, encrypted_valid); end
    end
    n_checks += 2;
    if (fifo_level !== LW'(4)) begin n_fail++; $display("FAIL bp_level got %0d want 4", fifo_level); end
    if (din_ready !== 1'b0) begin n_fail++; $display("FAIL bp_din_ready got %b want 0", din_ready); end
    mode = 1'b1;
    nout = 0;
    for (int c = 0; c < 12; c++) begin
      din_valid = (idx < 6);
      din = b[(idx < 6) ? idx : 5];
      acc = din_valid && (q.size() < DEPTH);
      tick();
      if (acc) idx++;
      if (encrypted_valid === 1'b1) begin
        want = permute(b[(nout < 6) ? nout : 5]) ^ key_for(nout, 0);
        n_checks += 1;
        if (nout >= 6 || encrypted_data !== want) begin
          n_fail++; $display("FAIL bp_out idx %0d got %h want %h", nout, encrypted_data, want);
        end
        nout++;
      end else if (nout > 0 && nout < 6) begin
        n_checks += 1; n_fail++;
        $display("FAIL bp_gap after %0d outputs got valid=%b want 1", nout, encrypted_valid);
      end
    end
    n_checks += 1;
    if (nout != 6) begin n_fail++; $display("FAIL bp_count got %0d want 6", nout); end
  endtask

  task automatic test_random_model();
    for (int seg = 0; seg < 4; seg++) begin
      rot_freq = 3'($urandom_range(0, 7));
      k1 = 8'($urandom); k2 = 8'($urandom); k3 = 8'($urandom);
      mode = 1'b0;
      idle(2);
      for (int c = 0; c < 50; c++) begin
        mode      = ($urandom_range(0, 9) != 0);
        din_valid = ($urandom_range(0, 3) != 0);
        din       = 8'($urandom);
        tick();
        n_checks += 4;
        if (encrypted_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid seg %0d cyc %0d got %b want %b", seg, c, encrypted_valid, m_valid); end
        if (encrypted_data !== m_data) begin n_fail++; $display("FAIL rnd_data seg %0d cyc %0d got %h want %h", seg, c, encrypted_data, m_data); end
        if (fifo_level !== LW'(q.size())) begin n_fail++; $display("FAIL rnd_level seg %0d cyc %0d got %0d want %0d", seg, c, fifo_level, q.size()); end
        if (din_ready !== (q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_din_ready seg %0d cyc %0d got %b want %b", seg, c, din_ready, q.size() < DEPTH); end
      end
    end
  endtask

  task automatic test_round_trip();
    logic       dec_prev;
    int         dn;
    logic [7:0] pt;
    for (int seg = 0; seg < 2; seg++) begin
      rot_freq = 3'($urandom_range(0, 7));
      k1 = 8'($urandom); k2 = 8'($urandom); k3 = 8'($urandom);
      mode = 1'b0;
      idle(2);
      dec_prev = 1'b0;
      dn = 0;
      for (int c = 0; c < 100; c++) begin
        rst = (seg == 1) && (c == 40 || c == 41);
        if (c >= 30 && c < 40) begin
          mode = 1'b1; din_valid = 1'b1;
        end else begin
          mode      = ($urandom_range(0, 7) != 0);
          din_valid = ($urandom_range(0, 2) != 0);
        end
        din = 8'($urandom);
        tick();
        n_checks += 1;
        if (encrypted_valid !== m_valid) begin
          n_fail++; $display("FAIL rt_valid seg %0d cyc %0d got %b want %b", seg, c, encrypted_valid, m_valid);
        end
        if (encrypted_valid === 1'b1) begin
          dn = dec_prev ? dn + 1 : 0;
          pt = unpermute(encrypted_data ^ key_for(dn, int'(rot_freq)));
          n_checks += 1;
          if (pt !== m_pt) begin
            n_fail++; $display("FAIL rt_plain seg %0d cyc %0d got %h want %h", seg, c, pt, m_pt);
          end
        end
        dec_prev = (encrypted_valid === 1'b1);
      end
      rst = 1'b0;
    end
  endtask

  initial begin
    q.delete();
    m_valid = 1'b0; m_data = 8'h00; m_pt = 8'h00; m_prev_pop = 1'b0; m_n = 0;
    rst = 1'b1; mode = 1'b0; din = 8'h00; din_valid = 1'b0;
    k1 = 8'h00; k2 = 8'h00; k3 = 8'h00; rot_freq = 3'd0;
    @(negedge clk);
    test_reset();
    test_rot_every_byte();
    test_rot_every_two();
    test_gap_restart();
    test_backpressure();
    test_random_model();
    test_round_trip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
